// File: rtl/alarm_controller_if.sv
// Alarm controller bus: time/button inputs from the clock front panel and stored alarm/status outputs.
interface alarm_controller_if;
    logic       sec_tick;
    logic [4:0] hours;
    logic [6:0] minutes;
    logic       alarm_enable;
    logic       set;
    logic [4:0] set_hours;
    logic [6:0] set_minutes;
    logic       snooze;
    logic       stop;
    logic [4:0] alarm_hours;
    logic [6:0] alarm_minutes;
    logic       ringing;
    logic       snoozing;

    modport master (
        output sec_tick, hours, minutes, alarm_enable, set, set_hours, set_minutes, snooze, stop,
        input  alarm_hours, alarm_minutes, ringing, snoozing
    );

    modport slave (
        input  sec_tick, hours, minutes, alarm_enable, set, set_hours, set_minutes, snooze, stop,
        output alarm_hours, alarm_minutes, ringing, snoozing
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm clock controller: stores the alarm time, rings once per matching minute,
// supports limited snoozes and an auto-stop ring timeout.
module alarm_controller #(
    parameter int unsigned SNOOZE_MIN       = 5,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic              clk,
    input  logic              reset,
    alarm_controller_if.slave bus
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 7;
    localparam int unsigned RW = 8;
    localparam int unsigned SW = 12;
    localparam int unsigned TW = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RINGING = 2'd1;
    localparam logic [1:0] S_SNOOZE  = 2'd2;

    localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MIN * 60);
    localparam logic [RW-1:0] RING_LIMIT  = RW'(RING_TIMEOUT_SEC);
    localparam logic [TW-1:0] TALLY_MAX   = TW'(MAX_SNOOZE);
    localparam logic [HW-1:0] HOURS_MAX   = HW'(23);
    localparam logic [MW-1:0] MINUTES_MAX = MW'(59);

    logic [1:0]    state_q,         state_d;
    logic [HW-1:0] alarm_hours_q,   alarm_hours_d;
    logic [MW-1:0] alarm_minutes_q, alarm_minutes_d;
    logic [TW-1:0] tally_q,         tally_d;
    logic          fired_q,         fired_d;
    logic          armed_q,         armed_d;
    logic [RW-1:0] ring_cnt_q,      ring_cnt_d;
    logic [SW-1:0] snooze_cnt_q,    snooze_cnt_d;
    logic          ringing_q,       ringing_d;
    logic          snoozing_q,      snoozing_d;

    logic set_ok_c;
    logic match_c;

    assign set_ok_c = bus.set && (bus.set_hours <= HOURS_MAX) && (bus.set_minutes <= MINUTES_MAX);
    assign match_c  = (bus.hours == alarm_hours_q) && (bus.minutes == alarm_minutes_q);

    // State register and all stored values; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            alarm_hours_q   <= '0;
            alarm_minutes_q <= '0;
            tally_q         <= '0;
            fired_q         <= 1'b0;
            armed_q         <= 1'b0;
            ring_cnt_q      <= '0;
            snooze_cnt_q    <= '0;
            ringing_q       <= 1'b0;
            snoozing_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            alarm_hours_q   <= alarm_hours_d;
            alarm_minutes_q <= alarm_minutes_d;
            tally_q         <= tally_d;
            fired_q         <= fired_d;
            armed_q         <= armed_d;
            ring_cnt_q      <= ring_cnt_d;
            snooze_cnt_q    <= snooze_cnt_d;
            ringing_q       <= ringing_d;
            snoozing_q      <= snoozing_d;
        end
    end

    // Next-state logic, branches ordered by same-cycle priority.
    always_comb begin
        state_d         = state_q;
        alarm_hours_d   = alarm_hours_q;
        alarm_minutes_d = alarm_minutes_q;
        tally_d         = tally_q;
        fired_d         = fired_q;
        armed_d         = armed_q;
        ring_cnt_d      = ring_cnt_q;
        snooze_cnt_d    = snooze_cnt_q;

        // armed stays low after reset until the time has been seen outside the alarm minute.
        if (!match_c) begin
            fired_d = 1'b0;
            armed_d = 1'b1;
        end

        if (set_ok_c) begin
            alarm_hours_d   = bus.set_hours;
            alarm_minutes_d = bus.set_minutes;
            state_d         = S_IDLE;
            tally_d         = '0;
            fired_d         = 1'b0;
            armed_d         = 1'b1;
            ring_cnt_d      = '0;
            snooze_cnt_d    = '0;
        end else if (!bus.alarm_enable) begin
            state_d = S_IDLE;
            tally_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.sec_tick && match_c && !fired_q && armed_q) begin
                        state_d    = S_RINGING;
                        fired_d    = 1'b1;
                        ring_cnt_d = '0;
                        tally_d    = '0;
                    end
                end
                S_RINGING: begin
                    if (bus.stop) begin
                        state_d = S_IDLE;
                        tally_d = '0;
                    end else if (bus.snooze && (tally_q < TALLY_MAX)) begin
                        state_d      = S_SNOOZE;
                        tally_d      = tally_q + TW'(1);
                        snooze_cnt_d = SNOOZE_LOAD;
                    end else if (bus.sec_tick) begin
                        if ((ring_cnt_q + RW'(1)) == RING_LIMIT) begin
                            state_d    = S_IDLE;
                            ring_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RW'(1);
                        end
                    end
                end
                S_SNOOZE: begin
                    if (bus.stop) begin
                        state_d = S_IDLE;
                        tally_d = '0;
                    end else if (bus.sec_tick) begin
                        if (snooze_cnt_q == SW'(1)) begin
                            state_d      = S_RINGING;
                            ring_cnt_d   = '0;
                            snooze_cnt_d = '0;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q - SW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        ringing_d  = (state_d == S_RINGING);
        snoozing_d = (state_d == S_SNOOZE);
    end

    assign bus.alarm_hours   = alarm_hours_q;
    assign bus.alarm_minutes = alarm_minutes_q;
    assign bus.ringing       = ringing_q;
    assign bus.snoozing      = snoozing_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus randomized traffic
// compared against a seconds-based behavioural model.
module tb_alarm_controller;

    localparam int RING_SEC = 60;
    localparam int SNZ_SEC  = 300;
    localparam int MAXS     = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alarm_controller_if bus ();

    alarm_controller #(
        .SNOOZE_MIN       (5),
        .RING_TIMEOUT_SEC (60),
        .MAX_SNOOZE       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: alarm time, ring/snooze flags, seconds rung, seconds of snooze left.
    int m_ah, m_am, m_tally, m_secs, m_left;
    bit m_ring, m_snz, m_fired, m_armed;

    task automatic model_reset();
        m_ah = 0; m_am = 0; m_tally = 0; m_secs = 0; m_left = 0;
        m_ring = 0; m_snz = 0; m_fired = 0; m_armed = 0;
    endtask

    task automatic model_edge();
        bit match, acc, nr, ns, nf, na;
        int nah, nam, nt, nsec, nl;
        match = (int'(bus.hours) == m_ah) && (int'(bus.minutes) == m_am);
        acc   = bus.set && (int'(bus.set_hours) <= 23) && (int'(bus.set_minutes) <= 59);
        nr = m_ring; ns = m_snz; nf = m_fired; na = m_armed;
        nah = m_ah; nam = m_am; nt = m_tally; nsec = m_secs; nl = m_left;
        if (!match) begin nf = 0; na = 1; end
        if (acc) begin
            nah = int'(bus.set_hours); nam = int'(bus.set_minutes);
            nr = 0; ns = 0; nt = 0; nf = 0; na = 1;
        end else if (!bus.alarm_enable) begin
            nr = 0; ns = 0; nt = 0;
        end else if (m_ring) begin
            if (bus.stop) begin nr = 0; nt = 0; end
            else if (bus.snooze && m_tally < MAXS) begin nr = 0; ns = 1; nt = m_tally + 1; nl = SNZ_SEC; end
            else if (bus.sec_tick) begin
                nsec = m_secs + 1;
                if (nsec == RING_SEC) nr = 0;
            end
        end else if (m_snz) begin
            if (bus.stop) begin ns = 0; nt = 0; end
            else if (bus.sec_tick) begin
                nl = m_left - 1;
                if (nl == 0) begin ns = 0; nr = 1; nsec = 0; end
            end
        end else if (bus.sec_tick && match && !m_fired && m_armed) begin
            nr = 1; nf = 1; nsec = 0; nt = 0;
        end
        m_ring = nr; m_snz = ns; m_fired = nf; m_armed = na;
        m_ah = nah; m_am = nam; m_tally = nt; m_secs = nsec; m_left = nl;
    endtask

    task automatic edge_clk();
        model_edge();
        @(posedge clk);
        #1;
        bus.sec_tick = 0; bus.snooze = 0; bus.stop = 0; bus.set = 0;
    endtask

    task automatic step(input bit t, input bit sn, input bit st);
        bus.sec_tick = t; bus.snooze = sn; bus.stop = st;
        edge_clk();
    endtask

    task automatic do_set(input int h, input int m);
        bus.set = 1; bus.set_hours = 5'(h); bus.set_minutes = 7'(m);
        edge_clk();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({bus.alarm_hours, bus.alarm_minutes, bus.ringing, bus.snoozing} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {bus.alarm_hours, bus.alarm_minutes, bus.ringing, bus.snoozing});
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_set_and_fire();
        bus.alarm_enable = 1; bus.hours = 6; bus.minutes = 29;
        do_set(6, 30);
        checks++;
        if (bus.alarm_hours !== 5'd6 || bus.alarm_minutes !== 7'd30) begin
            errors++; $display("FAIL set_load got %0d:%0d want 6:30", bus.alarm_hours, bus.alarm_minutes);
        end
        step(1, 0, 0); step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b0) begin errors++; $display("FAIL early_ring got %b want 0", bus.ringing); end
        bus.minutes = 30;
        step(0, 0, 0);
        checks++;
        if (bus.ringing !== 1'b0) begin errors++; $display("FAIL ring_without_tick got %b want 0", bus.ringing); end
        step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b1) begin errors++; $display("FAIL fire_on_tick got %b want 1", bus.ringing); end
        step(0, 0, 1);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        checks++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            errors++; $display("FAIL refire_after_stop got %b want 00", {bus.ringing, bus.snoozing});
        end
    endtask

    task automatic test_timeout();
        bus.minutes = 31;
        step(0, 0, 0);
        do_set(6, 31);
        step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b1) begin errors++; $display("FAIL timeout_start got %b want 1", bus.ringing); end
        for (int i = 0; i < RING_SEC - 1; i++) step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b1) begin errors++; $display("FAIL ring_tick59 got %b want 1", bus.ringing); end
        step(1, 0, 0);
        checks++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            errors++; $display("FAIL ring_tick60 got %b want 00", {bus.ringing, bus.snoozing});
        end
        step(1, 0, 0); step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b0) begin errors++; $display("FAIL no_refire_after_timeout got %b want 0", bus.ringing); end
    endtask

    task automatic test_snooze();
        bus.hours = 7; bus.minutes = 0;
        do_set(7, 0);
        step(1, 0, 0);
        for (int k = 0; k < MAXS; k++) begin
            step(0, 1, 0);
            checks++;
            if ({bus.ringing, bus.snoozing} !== 2'b01) begin
                errors++; $display("FAIL snooze_enter%0d got %b want 01", k, {bus.ringing, bus.snoozing});
            end
            for (int i = 0; i < SNZ_SEC - 1; i++) step(1, 0, 0);
            checks++;
            if ({bus.ringing, bus.snoozing} !== 2'b01) begin
                errors++; $display("FAIL snooze_tick299_%0d got %b want 01", k, {bus.ringing, bus.snoozing});
            end
            step(1, 0, 0);
            checks++;
            if ({bus.ringing, bus.snoozing} !== 2'b10) begin
                errors++; $display("FAIL snooze_tick300_%0d got %b want 10", k, {bus.ringing, bus.snoozing});
            end
        end
        step(0, 1, 0);
        checks++;
        if ({bus.ringing, bus.snoozing} !== 2'b10) begin
            errors++; $display("FAIL fourth_snooze got %b want 10", {bus.ringing, bus.snoozing});
        end
    endtask

    task automatic test_bad_set();
        do_set(24, 0);
        checks++;
        if ({bus.alarm_hours, bus.alarm_minutes, bus.ringing} !== {5'd7, 7'd0, 1'b1}) begin
            errors++; $display("FAIL bad_hours got %0d:%0d r=%b want 7:0 r=1", bus.alarm_hours, bus.alarm_minutes, bus.ringing);
        end
        do_set(12, 60);
        checks++;
        if ({bus.alarm_hours, bus.alarm_minutes, bus.ringing} !== {5'd7, 7'd0, 1'b1}) begin
            errors++; $display("FAIL bad_minutes got %0d:%0d r=%b want 7:0 r=1", bus.alarm_hours, bus.alarm_minutes, bus.ringing);
        end
    endtask

    task automatic test_priority();
        step(0, 1, 1);
        checks++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            errors++; $display("FAIL stop_and_snooze got %b want 00", {bus.ringing, bus.snoozing});
        end
        do_set(7, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        bus.alarm_enable = 0;
        step(0, 0, 0);
        checks++;
        if ({bus.ringing, bus.snoozing} !== 2'b00) begin
            errors++; $display("FAIL disable_in_snooze got %b want 00", {bus.ringing, bus.snoozing});
        end
        bus.alarm_enable = 1;
    endtask

    task automatic test_reset_mid_snooze();
        do_set(7, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.alarm_hours, bus.alarm_minutes, bus.ringing, bus.snoozing} !== 14'd0) begin
            errors++; $display("FAIL async_reset got %h want 0", {bus.alarm_hours, bus.alarm_minutes, bus.ringing, bus.snoozing});
        end
        bus.hours = 0; bus.minutes = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b0) begin errors++; $display("FAIL ring_after_reset got %b want 0", bus.ringing); end
        bus.minutes = 1;
        step(0, 0, 0);
        bus.minutes = 0;
        step(1, 0, 0);
        checks++;
        if (bus.ringing !== 1'b1) begin errors++; $display("FAIL reenter_midnight got %b want 1", bus.ringing); end
        step(0, 0, 1);
    endtask

    task automatic test_random();
        reset = 1'b0;
        model_reset();
        #3;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.hours = 0; bus.minutes = 5;
        for (int c = 0; c < 8000; c++) begin
            bus.alarm_enable = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 59) == 0) begin
                bus.set = 1;
                bus.set_hours = 5'($urandom_range(0, 25));
                bus.set_minutes = 7'($urandom_range(0, 61));
            end
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.hours = 5'(m_ah); bus.minutes = 7'(m_am);
                end else begin
                    bus.hours = 5'($urandom_range(0, 23)); bus.minutes = 7'($urandom_range(0, 59));
                end
            end
            bus.sec_tick = ($urandom_range(0, 1) == 0);
            bus.snooze   = ($urandom_range(0, 29) == 0);
            bus.stop     = ($urandom_range(0, 89) == 0);
            edge_clk();
            checks++;
            if ({bus.alarm_hours, bus.alarm_minutes, bus.ringing, bus.snoozing} !==
                {5'(m_ah), 7'(m_am), m_ring, m_snz}) begin
                errors++;
                $display("FAIL random_cycle%0d got %0d:%0d r=%b s=%b want %0d:%0d r=%b s=%b", c,
                         bus.alarm_hours, bus.alarm_minutes, bus.ringing, bus.snoozing,
                         m_ah, m_am, m_ring, m_snz);
            end
        end
    endtask

    initial begin
        bus.sec_tick = 0; bus.hours = 0; bus.minutes = 0; bus.alarm_enable = 0;
        bus.set = 0; bus.set_hours = 0; bus.set_minutes = 0; bus.snooze = 0; bus.stop = 0;
        model_reset();
        test_reset();
        test_set_and_fire();
        test_timeout();
        test_snooze();
        test_bad_set();
        test_priority();
        test_reset_mid_snooze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Parameters
REQ-001 SHALL provide SNOOZE_MIN, default 5, snooze length in minutes (legal 1..30).
REQ-002 SHALL provide RING_TIMEOUT_SEC, default 60, seconds of ringing before auto-stop (legal 1..255).
REQ-003 SHALL provide MAX_SNOOZE, default 3, snoozes allowed per alarm event (legal 1..3).

Interface
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sec_tick  input  1  one-clk-wide pulse, once per second, synchronous to clk.
REQ-007 hours  input  5  current time hours from the hour counter, 0..23.
REQ-008 minutes  input  7  current time minutes from the minute counter, 0..59.
REQ-009 alarm_enable  input  1  level; alarm armed when 1.
REQ-010 set  input  1  one-clk pulse; load alarm time.
REQ-011 set_hours  input  5  alarm hours to load.
REQ-012 set_minutes  input  7  alarm minutes to load.
REQ-013 snooze  input  1  one-clk pulse from the snooze button.
REQ-014 stop  input  1  one-clk pulse from the stop button.
REQ-015 alarm_hours  output  5  stored alarm hours.
REQ-016 alarm_minutes  output  7  stored alarm minutes.
REQ-017 ringing  output  1  1 while in RINGING.
REQ-018 snoozing  output  1  1 while in SNOOZE.

Function
REQ-019 States SHALL be IDLE, RINGING, SNOOZE; ringing/snoozing SHALL be registered decodes of the state.
REQ-020 set SHALL load alarm_hours/alarm_minutes only if set_hours<=23 and set_minutes<=59; otherwise the pulse is ignored entirely.
REQ-021 An accepted set SHALL force IDLE, clear the snooze tally and the fired flag, in any state.
REQ-022 match = (hours==alarm_hours && minutes==alarm_minutes); IDLE->RINGING SHALL occur on the first sec_tick cycle with match=1, alarm_enable=1, fired=0; entering RINGING sets fired.
REQ-023 fired SHALL clear on any clk with match=0, so the alarm fires exactly once per matching minute.
REQ-024 RINGING: ring counter SHALL clear on entry, increment per sec_tick; on the sec_tick making it RING_TIMEOUT_SEC SHALL go IDLE.
REQ-025 RINGING + snooze, tally<MAX_SNOOZE: SHALL go SNOOZE, increment tally, load snooze counter with SNOOZE_MIN*60 (12-bit).
REQ-026 RINGING + snooze, tally==MAX_SNOOZE: snooze SHALL be ignored; ringing continues.
REQ-027 SNOOZE: snooze counter SHALL decrement per sec_tick; on the sec_tick reaching 0 SHALL go RINGING (ring counter cleared), independent of match.
REQ-028 stop in RINGING or SNOOZE SHALL go IDLE and clear the tally; fired SHALL stay set.
REQ-029 alarm_enable=0 SHALL force IDLE and clear the tally on the next clk, in any state.
REQ-030 Same-cycle priority, highest first: accepted set, alarm_enable=0, stop, snooze, sec_tick-driven transitions.
REQ-031 Transitions SHALL take effect on the clk edge that samples the qualifying inputs; outputs update the same edge (latency 1 clk).
REQ-032 Hours/minutes wrap (23:59->00:00) SHALL need no special handling; comparison is equality only.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE, alarm_hours=0, alarm_minutes=0, ringing=0, snoozing=0, and clear tally, fired, ring and snooze counters.
REQ-034 reset asserted mid-RINGING or mid-SNOOZE SHALL abort with no residual state; after release with time 00:00, enable=1, no ring until time leaves and re-enters 00:00.

Verification
REQ-035 set 06:30, enable=1, time 06:29->06:30 -> ringing=1 on the first sec_tick at 06:30; no re-fire within 06:30 after stop.
REQ-036 RINGING, 60 sec_ticks, no button -> ringing=0 after the 60th tick, state IDLE.
REQ-037 snooze while ringing (SNOOZE_MIN=5) -> snoozing=1; ringing=1 again on the 300th sec_tick; fourth snooze ignored.
REQ-038 set 24:00 or 12:60 -> alarm_hours/alarm_minutes unchanged, state unchanged.
REQ-039 stop and snooze same cycle in RINGING -> IDLE, tally=0; alarm_enable=0 while SNOOZE -> IDLE next clk.
REQ-040 reset low mid-SNOOZE -> all outputs 0 asynchronously, before the next clk edge.
